sram_bank_sequencer: RTL and testbench

//  Upstream control stage for the 2-port SRAM register bank. Accepts one access request per

---
 rtl/sram_bank_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_sram_bank_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_sequencer.sv
// sram_bank_sequencer
// Accepts one register-bank access per instruction window and replays it onto the
// 2-port SRAM bank at fixed steps of the window. Read data is captured while the
// read window is closing and returned with a single-cycle valid pulse.
module sram_bank_sequencer #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int CYCLE_LEN = 20,
  parameter int ADDR_STEP = 2,
  parameter int DATA_STEP = 4,
  parameter int RD_START  = 6,
  parameter int RD_END    = 8,
  parameter int WR_START  = 8,
  parameter int WR_END    = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_flag,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rd_en,
  input  logic              req_wr_en,
  input  logic [ADDR_W-1:0] req_raddr_a,
  input  logic [ADDR_W-1:0] req_raddr_b,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] sram_in,
  output logic              read_en,
  output logic              write_en,
  input  logic [DATA_W-1:0] sram_out_a,
  input  logic [DATA_W-1:0] sram_out_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rdata_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int STEP_W = (CYCLE_LEN > 1) ? $clog2(CYCLE_LEN) : 1;

  localparam logic [STEP_W-1:0] LAST_S = STEP_W'(CYCLE_LEN - 1);
  localparam logic [STEP_W-1:0] ADDR_S = STEP_W'(ADDR_STEP);
  localparam logic [STEP_W-1:0] DATA_S = STEP_W'(DATA_STEP);
  localparam logic [STEP_W-1:0] RD_S   = STEP_W'(RD_START);
  localparam logic [STEP_W-1:0] RD_E   = STEP_W'(RD_END);
  localparam logic [STEP_W-1:0] WR_S   = STEP_W'(WR_START);
  localparam logic [STEP_W-1:0] WR_E   = STEP_W'(WR_END);

  // The step schedule only makes sense in this order; refuse to build otherwise.
  generate
    if (!(ADDR_STEP < DATA_STEP && DATA_STEP <= RD_START && RD_START < RD_END &&
          RD_END <= WR_START && WR_START < WR_END && WR_END <= CYCLE_LEN - 1)) begin : g_bad_schedule
      $error("sram_bank_sequencer: step schedule ordering violated");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [STEP_W-1:0] step_reg, step_next;
  logic              win_live;   // step_next is a real step of the current window

  logic              rq_rd_en, rq_wr_en;
  logic [ADDR_W-1:0] rq_addr_a, rq_addr_b;
  logic [DATA_W-1:0] rq_wdata;

  logic [ADDR_W-1:0] addr_a_next, addr_b_next;
  logic [DATA_W-1:0] sram_in_next, rdata_a_next, rdata_b_next;
  logic              read_en_next, write_en_next, rdata_valid_next, overrun_next;

  logic accept;

  assign accept    = (state_reg == IDLE) && req_valid;
  assign req_ready = (state_reg == IDLE) && !reset;
  assign busy      = (state_reg != IDLE);

  // State, step counter and the latched request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      step_reg  <= '0;
      rq_rd_en  <= 1'b0;
      rq_wr_en  <= 1'b0;
      rq_addr_a <= '0;
      rq_addr_b <= '0;
      rq_wdata  <= '0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      if (accept) begin
        rq_rd_en  <= req_rd_en;
        rq_wr_en  <= req_wr_en;
        rq_addr_a <= req_raddr_a;
        rq_addr_b <= req_raddr_b;
        rq_wdata  <= req_wdata;
      end
    end
  end

  // Next state and next step; an inst_flag in the accepting cycle is ignored,
  // so ARMED always lasts at least one cycle.
  always_comb begin
    state_next = state_reg;
    step_next  = '0;
    win_live   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) state_next = ARMED;
      end
      ARMED: begin
        if (inst_flag) begin
          state_next = ACTIVE;
          win_live   = 1'b1;
        end
      end
      ACTIVE: begin
        if (step_reg == LAST_S) begin
          state_next = IDLE;
        end else begin
          step_next = step_reg + STEP_W'(1);
          win_live  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output values for the step about to begin, so the registered bank controls
  // line up exactly with the step counter.
  always_comb begin
    addr_a_next      = addr_a;
    addr_b_next      = addr_b;
    sram_in_next     = sram_in;
    rdata_a_next     = rdata_a;
    rdata_b_next     = rdata_b;
    read_en_next     = 1'b0;
    write_en_next    = 1'b0;
    rdata_valid_next = 1'b0;
    overrun_next     = overrun || ((state_reg == ACTIVE) && inst_flag);
    if (win_live) begin
      if (step_next == ADDR_S) begin
        addr_a_next = rq_addr_a;
        addr_b_next = rq_addr_b;
      end
      if ((step_next == DATA_S) && rq_wr_en) sram_in_next = rq_wdata;
      read_en_next  = rq_rd_en && (step_next >= RD_S) && (step_next < RD_E);
      write_en_next = rq_wr_en && (step_next >= WR_S) && (step_next < WR_E);
      // Sample the bank on the edge that closes the read window, while ReadEn is still high.
      if ((step_next == RD_E) && rq_rd_en) begin
        rdata_a_next     = sram_out_a;
        rdata_b_next     = sram_out_b;
        rdata_valid_next = 1'b1;
      end
    end
  end

  // Registered outputs; reset drops the enables immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_a      <= '0;
      addr_b      <= '0;
      sram_in     <= '0;
      read_en     <= 1'b0;
      write_en    <= 1'b0;
      rdata_a     <= '0;
      rdata_b     <= '0;
      rdata_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      addr_a      <= addr_a_next;
      addr_b      <= addr_b_next;
      sram_in     <= sram_in_next;
      read_en     <= read_en_next;
      write_en    <= write_en_next;
      rdata_a     <= rdata_a_next;
      rdata_b     <= rdata_b_next;
      rdata_valid <= rdata_valid_next;
      overrun     <= overrun_next;
    end
  end

endmodule

// File: tb/tb_sram_bank_sequencer.sv
// Testbench for sram_bank_sequencer: a behavioural 32x16 bank is attached to the
// sequencer, requests are generated directed and at random, and read responses
// are compared by a monitor against expectations queued when each request is issued.
module tb_sram_bank_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_flag;
  logic        req_valid;
  logic        req_ready;
  logic        req_rd_en;
  logic        req_wr_en;
  logic [4:0]  req_raddr_a;
  logic [4:0]  req_raddr_b;
  logic [15:0] req_wdata;
  logic [4:0]  addr_a;
  logic [4:0]  addr_b;
  logic [15:0] sram_in;
  logic        read_en;
  logic        write_en;
  logic [15:0] sram_out_a;
  logic [15:0] sram_out_b;
  logic [15:0] rdata_a;
  logic [15:0] rdata_b;
  logic        rdata_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;
  exp_t exp_q[$];

  // reference register contents (what the bank should hold)
  logic [15:0] ref_mem [32];
  // previously driven held values and sticky overrun expectation
  logic [4:0]  prev_a, prev_b;
  logic [15:0] prev_d;
  bit          exp_overrun;
  // request presented early for the back-to-back case
  bit          pend_rd, pend_wr;
  logic [4:0]  pend_a, pend_b;
  logic [15:0] pend_d;

  sram_bank_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .inst_flag   (inst_flag),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd_en   (req_rd_en),
    .req_wr_en   (req_wr_en),
    .req_raddr_a (req_raddr_a),
    .req_raddr_b (req_raddr_b),
    .req_wdata   (req_wdata),
    .addr_a      (addr_a),
    .addr_b      (addr_b),
    .sram_in     (sram_in),
    .read_en     (read_en),
    .write_en    (write_en),
    .sram_out_a  (sram_out_a),
    .sram_out_b  (sram_out_b),
    .rdata_a     (rdata_a),
    .rdata_b     (rdata_b),
    .rdata_valid (rdata_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // behavioural 2-port bank: combinational reads while ReadEn, writes port A on WriteEn
  logic [15:0] bank_mem [32];
  assign sram_out_a = read_en ? bank_mem[addr_a] : 16'h0000;
  assign sram_out_b = read_en ? bank_mem[addr_b] : 16'h0000;
  always @(posedge clk) begin
    if (write_en) bank_mem[addr_a] <= sram_in;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h t=%0t", name, got, req, $time);
    end
  endtask

  // monitor: every rdata_valid pulse must match the oldest outstanding read
  always @(negedge clk) begin
    if (rdata_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rdata got a=%h b=%h required no response t=%0t", rdata_a, rdata_b, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rdata_a", {16'h0, rdata_a}, {16'h0, e.a});
        check("rdata_b", {16'h0, rdata_b}, {16'h0, e.b});
        $display("read response a=%h b=%h", rdata_a, rdata_b);
      end
    end
  end

  // Issue one request and walk its whole window, checking the per-step bank controls.
  task automatic run_req(input bit rd, input bit wr, input logic [4:0] a, input logic [4:0] b,
                         input logic [15:0] d, input int flag_step, input int reset_step,
                         input bit flag_at_accept, input bit hold_next);
    int n;
    int armed;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_rd_en   = rd;
    req_wr_en   = wr;
    req_raddr_a = a;
    req_raddr_b = b;
    req_wdata   = d;
    req_valid   = 1'b1;
    inst_flag   = flag_at_accept;
    if (rd && reset_step < 0) exp_q.push_back('{a: ref_mem[a], b: ref_mem[b]});
    if (wr && reset_step < 0) ref_mem[a] = d;
    $display("request rd=%0b wr=%0b a=%0d b=%0d wdata=%h flag_step=%0d reset_step=%0d",
             rd, wr, a, b, d, flag_step, reset_step);
    @(negedge clk);
    // accepted; scramble the request inputs to prove they were latched
    req_valid   = 1'b0;
    inst_flag   = 1'b0;
    req_rd_en   = 1'($urandom);
    req_wr_en   = 1'($urandom);
    req_raddr_a = 5'($urandom);
    req_raddr_b = 5'($urandom);
    req_wdata   = 16'($urandom);
    armed = flag_at_accept ? 1 : $urandom_range(0, 3);
    for (int k = 0; k < armed; k++) begin
      check("armed_busy", {31'h0, busy}, 32'h1);
      check("armed_ready", {31'h0, req_ready}, 32'h0);
      check("armed_enables", {30'h0, read_en, write_en}, 32'h0);
      @(negedge clk);
    end
    check("armed_busy", {31'h0, busy}, 32'h1);
    inst_flag = 1'b1;
    @(negedge clk);
    inst_flag = 1'b0;
    for (int s = 0; s < 20; s++) begin
      if (s == reset_step) begin
        reset = 1'b1;
        #1;
        check("rst_read_en", {31'h0, read_en}, 32'h0);
        check("rst_outputs", {addr_a, addr_b, 5'h0, write_en, rdata_valid, busy, req_ready, overrun},
              32'h0);
        check("rst_data", {sram_in, rdata_a}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("rst_no_valid", {31'h0, rdata_valid}, 32'h0);
        reset = 1'b0;
        prev_a = '0;
        prev_b = '0;
        prev_d = '0;
        exp_overrun = 1'b0;
        @(negedge clk);
        check("rst_release_ready", {30'h0, req_ready, busy}, 32'h2);
        return;
      end
      check($sformatf("read_en_s%0d", s), {31'h0, read_en}, {31'h0, rd && s >= 6 && s < 8});
      check($sformatf("write_en_s%0d", s), {31'h0, write_en}, {31'h0, wr && s == 8});
      check($sformatf("rdata_valid_s%0d", s), {31'h0, rdata_valid}, {31'h0, rd && s == 8});
      check($sformatf("addr_s%0d", s), {22'h0, addr_a, addr_b},
            {22'h0, (s >= 2) ? a : prev_a, (s >= 2) ? b : prev_b});
      check($sformatf("sram_in_s%0d", s), {16'h0, sram_in}, {16'h0, (wr && s >= 4) ? d : prev_d});
      check($sformatf("busy_ready_s%0d", s), {30'h0, busy, req_ready}, 32'h2);
      check($sformatf("overrun_s%0d", s), {31'h0, overrun},
            {31'h0, exp_overrun || (flag_step >= 0 && s > flag_step)});
      inst_flag = (s == flag_step);
      if (hold_next && s == 10) begin
        req_rd_en   = pend_rd;
        req_wr_en   = pend_wr;
        req_raddr_a = pend_a;
        req_raddr_b = pend_b;
        req_wdata   = pend_d;
        req_valid   = 1'b1;
      end
      @(negedge clk);
    end
    inst_flag = 1'b0;
    prev_a = a;
    prev_b = b;
    if (wr) prev_d = d;
    if (flag_step >= 0) exp_overrun = 1'b1;
    check("window_end_idle", {30'h0, busy, req_ready}, 32'h1);
  endtask

  initial begin
    reset       = 1'b1;
    inst_flag   = 1'b0;
    req_valid   = 1'b0;
    req_rd_en   = 1'b0;
    req_wr_en   = 1'b0;
    req_raddr_a = '0;
    req_raddr_b = '0;
    req_wdata   = '0;
    prev_a      = '0;
    prev_b      = '0;
    prev_d      = '0;
    exp_overrun = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {addr_a, addr_b, 5'h0, read_en, write_en, rdata_valid, busy, overrun, req_ready},
          32'h0);
    check("reset_data", {sram_in, rdata_a}, 32'h0);
    check("reset_rdata_b", {16'h0, rdata_b}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {30'h0, req_ready, busy}, 32'h2);

    // fill every register so later reads have known contents
    for (int i = 0; i < 32; i++) run_req(0, 1, 5'(i), 5'($urandom), 16'($urandom), -1, -1, 0, 0);

    // write then read back
    run_req(0, 1, 5'd1, 5'd0, 16'hAAAA, -1, -1, 0, 0);
    run_req(1, 0, 5'd1, 5'd2, 16'h0000, -1, -1, 0, 0);
    // read+write returns old contents, then new
    run_req(0, 1, 5'd3, 5'd0, 16'h00FF, -1, -1, 0, 0);
    run_req(1, 1, 5'd3, 5'd4, 16'h1234, -1, -1, 0, 0);
    run_req(1, 0, 5'd3, 5'd3, 16'h0000, -1, -1, 0, 0);
    // no-op window, and inst_flag coinciding with acceptance
    run_req(0, 0, 5'd7, 5'd9, 16'hBEEF, -1, -1, 1, 0);
    // back-to-back: second request held valid during the first window
    pend_rd = 1; pend_wr = 0; pend_a = 5'd3; pend_b = 5'd1; pend_d = 16'h5555;
    run_req(0, 1, 5'd1, 5'd2, 16'hC0DE, -1, -1, 0, 1);
    run_req(pend_rd, pend_wr, pend_a, pend_b, pend_d, -1, -1, 0, 0);
    // extra inst_flag inside the window
    run_req(1, 0, 5'd5, 5'd6, 16'h0000, 5, -1, 0, 0);

    // randomized traffic
    for (int i = 0; i < 25; i++)
      run_req(1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 18)) : -1, -1,
              1'($urandom_range(0, 3) == 0), 0);

    // reset in the middle of a read window, then normal operation resumes
    run_req(1, 0, 5'd1, 5'd3, 16'h0000, -1, 7, 0, 0);
    for (int i = 0; i < 3; i++)
      run_req(1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), -1, -1, 0, 0);

    repeat (3) @(negedge clk);
    check("all_reads_returned", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
